// File: rtl/lock_ctrl_if.sv
// lock_ctrl_if -- keypad lock handshake bundle.
//   match      : code detector level, high while the accepted sequence is held
//   entry_done : one-cycle pulse ending a code entry (match sampled with it)
//   door_open  : door sensor, 1 = open
//   unlock     : bolt release
//   alarm      : alarm indicator
//   locked_out : high while in lockout
//   fail_cnt   : consecutive wrong-entry count
// master drives the sensor/keypad side, slave is the lock controller.
interface lock_ctrl_if;
   logic       match;
   logic       entry_done;
   logic       door_open;
   logic       unlock;
   logic       alarm;
   logic       locked_out;
   logic [2:0] fail_cnt;

   modport master (
      output match, entry_done, door_open,
      input  unlock, alarm, locked_out, fail_cnt
   );

   modport slave (
      input  match, entry_done, door_open,
      output unlock, alarm, locked_out, fail_cnt
   );
endinterface

// File: rtl/lock_ctrl.sv
// lock_ctrl -- door lock controller with wrong-entry lockout and forced-entry
// alarm. All outputs are registered; every input takes effect on the output
// one cycle after it is sampled.
// Ports:
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : lock_ctrl_if.slave (match, entry_done, door_open in;
//          unlock, alarm, locked_out, fail_cnt out)
module lock_ctrl #(
   parameter int UNLOCK_CYCLES  = 16,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rstn,
   lock_ctrl_if.slave  bus
);

   // Timer only ever holds a load value of (cycles - 1), so clog2 of the
   // larger duration is enough bits.
   localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
   localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [2:0]    MAX_F        = 3'(MAX_FAILS);

   typedef enum logic [1:0] {
      LOCKED    = 2'd0,
      UNLOCKED  = 2'd1,
      DOOR_OPEN = 2'd2,
      LOCKOUT   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          unlock_q, unlock_d;
   logic          alarm_q, alarm_d;
   logic          locked_out_q, locked_out_d;
   logic [2:0]    fail_q, fail_d;
   logic [2:0]    fail_inc_s;

   // fail_cnt is always below MAX_FAILS while LOCKED, so this cannot wrap.
   assign fail_inc_s = fail_q + 3'd1;

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      unlock_d     = unlock_q;
      alarm_d      = alarm_q;
      locked_out_d = locked_out_q;
      fail_d       = fail_q;
      case (state_q)
         LOCKED: begin
            if (bus.entry_done && bus.match) begin
               state_d  = UNLOCKED;
               unlock_d = 1'b1;
               fail_d   = 3'd0;
               alarm_d  = 1'b0;
               timer_d  = UNLOCK_LOAD;
            end else begin
               // Forced entry: alarm latches until a correct entry or reset.
               if (bus.door_open) begin
                  alarm_d = 1'b1;
               end else begin
                  alarm_d = alarm_q;
               end
               if (bus.entry_done) begin
                  if (fail_inc_s == MAX_F) begin
                     state_d      = LOCKOUT;
                     locked_out_d = 1'b1;
                     alarm_d      = 1'b1;
                     fail_d       = MAX_F;
                     timer_d      = LOCKOUT_LOAD;
                  end else begin
                     fail_d = fail_inc_s;
                  end
               end else begin
                  fail_d = fail_q;
               end
            end
         end
         UNLOCKED: begin
            // Door opening wins over expiry and freezes the timer.
            if (bus.door_open) begin
               state_d = DOOR_OPEN;
            end else if (timer_q == '0) begin
               state_d  = LOCKED;
               unlock_d = 1'b0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         DOOR_OPEN: begin
            // Relock as soon as the door closes; no remaining time is honoured.
            if (!bus.door_open) begin
               state_d  = LOCKED;
               unlock_d = 1'b0;
            end else begin
               unlock_d = 1'b1;
            end
         end
         LOCKOUT: begin
            if (timer_q == '0) begin
               state_d      = LOCKED;
               locked_out_d = 1'b0;
               alarm_d      = 1'b0;
               fail_d       = 3'd0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            state_d      = LOCKED;
            timer_d      = '0;
            unlock_d     = 1'b0;
            alarm_d      = 1'b0;
            locked_out_d = 1'b0;
            fail_d       = 3'd0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= LOCKED;
         timer_q      <= '0;
         unlock_q     <= 1'b0;
         alarm_q      <= 1'b0;
         locked_out_q <= 1'b0;
         fail_q       <= 3'd0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         unlock_q     <= unlock_d;
         alarm_q      <= alarm_d;
         locked_out_q <= locked_out_d;
         fail_q       <= fail_d;
      end
   end

   assign bus.unlock     = unlock_q;
   assign bus.alarm      = alarm_q;
   assign bus.locked_out = locked_out_q;
   assign bus.fail_cnt   = fail_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Testbench for lock_ctrl: vector table, directed multi-cycle sequences and
// randomized traffic, all checked against a behavioural model.
module tb_lock_ctrl;

   localparam int UC  = 16;
   localparam int MF  = 3;
   localparam int LC  = 64;

   logic clk;
   logic rstn;
   lock_ctrl_if bus_if ();

   lock_ctrl #(.UNLOCK_CYCLES(UC), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: "phase" plus number of output cycles still owed.
   localparam int P_IDLE = 0, P_OPEN_TIMED = 1, P_OPEN_HELD = 2, P_BANNED = 3;
   int m_phase = P_IDLE;
   int m_left  = 0;
   int m_fail  = 0;
   int m_alarm = 0;

   task automatic model_update(input logic r, e, m, d);
      if (!r) begin
         m_phase = P_IDLE; m_left = 0; m_fail = 0; m_alarm = 0;
      end else begin
         case (m_phase)
            P_IDLE: begin
               if (e && m) begin
                  m_phase = P_OPEN_TIMED; m_left = UC; m_fail = 0; m_alarm = 0;
               end else begin
                  if (d) m_alarm = 1;
                  if (e) begin
                     m_fail = m_fail + 1;
                     if (m_fail == MF) begin
                        m_phase = P_BANNED; m_left = LC; m_alarm = 1;
                     end
                  end
               end
            end
            P_OPEN_TIMED: begin
               if (d) m_phase = P_OPEN_HELD;
               else begin
                  m_left = m_left - 1;
                  if (m_left == 0) m_phase = P_IDLE;
               end
            end
            P_OPEN_HELD: if (!d) m_phase = P_IDLE;
            default: begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_phase = P_IDLE; m_fail = 0; m_alarm = 0;
               end
            end
         endcase
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, then compare the DUT with the model.
   task automatic step(input logic r, e, m, d);
      int exp_v, act_v;
      rstn = r;
      bus_if.entry_done = e;
      bus_if.match = m;
      bus_if.door_open = d;
      @(posedge clk);
      model_update(r, e, m, d);
      #1;
      exp_v = ((m_phase == P_OPEN_TIMED || m_phase == P_OPEN_HELD) ? 32 : 0) +
              (m_alarm * 16) + ((m_phase == P_BANNED) ? 8 : 0) + m_fail;
      act_v = {26'd0, bus_if.unlock, bus_if.alarm, bus_if.locked_out, bus_if.fail_cnt};
      check("model{unlock,alarm,locked_out,fail_cnt}", act_v, exp_v);
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_outs(input string name, input int u, a, l, f);
      check({name, ".unlock"}, int'(bus_if.unlock), u);
      check({name, ".alarm"}, int'(bus_if.alarm), a);
      check({name, ".locked_out"}, int'(bus_if.locked_out), l);
      check({name, ".fail_cnt"}, int'(bus_if.fail_cnt), f);
   endtask

   typedef struct {
      logic r, e, m, d;
      int   u, a, l, f;
   } vec_t;

   vec_t tbl[10];

   initial begin
      rstn = 1'b0;
      bus_if.entry_done = 1'b0;
      bus_if.match = 1'b0;
      bus_if.door_open = 1'b0;

      // r e m d   unlock alarm locked_out fail_cnt
      tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0}; // reset ignores inputs
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1}; // first wrong entry
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1}; // idle
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1}; // match alone: no effect
      tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 2}; // second wrong
      tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 0, 0}; // correct entry
      tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0}; // entry ignored while open
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0}; // reset mid-unlock
      tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1}; // wrong after reset
      tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 0, 1}; // forced entry
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].d);
         check_outs($sformatf("tbl[%0d]", i), tbl[i].u, tbl[i].a, tbl[i].l, tbl[i].f);
      end

      // Correct entry: exactly UC cycles of unlock.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check_outs("open.c1", 1, 0, 0, 0);
      for (int i = 2; i <= UC; i++) begin
         idle();
         check($sformatf("open.c%0d.unlock", i), int'(bus_if.unlock), 1);
      end
      idle();
      check_outs("open.relock", 0, 0, 0, 0);

      // Lockout after MF wrong entries; correct entry during lockout ignored.
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_outs("lo.w1", 0, 0, 0, 1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_outs("lo.w2", 0, 0, 0, 2);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_outs("lo.enter", 0, 1, 1, 3);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check_outs("lo.ignore", 0, 1, 1, 3);
      for (int i = 3; i <= LC; i++) begin
         idle();
         check($sformatf("lo.c%0d.locked_out", i), int'(bus_if.locked_out), 1);
      end
      idle();
      check_outs("lo.exit", 0, 0, 0, 0);

      // Wrong, wrong, right, wrong: no lockout.
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_outs("wr.f2", 0, 0, 0, 2);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check_outs("wr.right", 1, 0, 0, 0);
      for (int i = 0; i < UC; i++) idle();
      check_outs("wr.relock", 0, 0, 0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_outs("wr.wrong", 0, 0, 0, 1);

      // Door hold: open at cycle 5 for 40 cycles.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i < 5; i++) idle();
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1);
         check($sformatf("hold.c%0d.unlock", i + 5), int'(bus_if.unlock), 1);
      end
      idle();
      check_outs("hold.close", 0, 0, 0, 0);

      // Forced entry alarm persists until a correct entry.
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check_outs("force.open", 0, 1, 0, 0);
      idle();
      idle();
      check_outs("force.persist", 0, 1, 0, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check_outs("force.clear", 1, 0, 0, 0);

      // Reset at cycle 8 of unlock, then at cycle 30 of lockout.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i < 8; i++) idle();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check_outs("rst.unl", 0, 0, 0, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check_outs("rst.unl.after", 1, 0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < MF; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 30; i++) idle();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check_outs("rst.lo", 0, 0, 0, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check_outs("rst.lo.after", 1, 0, 0, 0);

      // Randomized traffic against the model.
      begin
         logic d_lvl;
         d_lvl = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) d_lvl = ~d_lvl;
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)),
                 d_lvl);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
